// File: rtl/wb_arbiter_2m.sv
// -----------------------------------------------------------------------------
// wb_arbiter_2m
//
// Two-master / one-slave Wishbone arbiter that sits in front of the frequency
// counter's shared register bus. Master 0 is the control unit, master 1 is the
// UART command bridge. The bus is granted for a whole Wishbone cycle, ties are
// broken round-robin, and a master holding LOCK keeps the grant across gaps in
// its CYC. Only the granted master is muxed onto the slave and only it sees
// ack/err/rty; slave read data is broadcast to both masters.
//
// Build option:
//   WB_ARB_TIMEOUT_EN - when defined, a stall counter forces an error to the
//                       granted master after TIMEOUT_CYCLES cycles of strobe
//                       with no slave response. Undefined by default, in which
//                       case the arbiter waits on the slave indefinitely.
//
// Parameters:
//   AW, DW, SW      address / data / byte-select widths
//   TIMEOUT_CYCLES  stall limit for the optional timeout
//
// Ports:
//   clk_i, rst_i                   clock, synchronous active-high reset
//   m0_*_i / m1_*_i                master requests (cyc, stb, we, lock, addr,
//                                  write data, select)
//   m0_*_o / m1_*_o                read data, ack, err, rty back to masters
//   s_*_o                          muxed request towards the slave
//   s_dat_i, s_ack_i, s_err_i,
//   s_rty_i                        slave responses
//   gnt_o                          one-hot grant (bit0 = m0, bit1 = m1)
// -----------------------------------------------------------------------------
module wb_arbiter_2m #(
  parameter int AW             = 32,
  parameter int DW             = 32,
  parameter int SW             = 8,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic          clk_i,
  input  logic          rst_i,

  input  logic          m0_cyc_i,
  input  logic          m0_stb_i,
  input  logic          m0_we_i,
  input  logic          m0_lock_i,
  input  logic [AW-1:0] m0_addr_i,
  input  logic [DW-1:0] m0_dat_i,
  input  logic [SW-1:0] m0_sel_i,
  output logic [DW-1:0] m0_dat_o,
  output logic          m0_ack_o,
  output logic          m0_err_o,
  output logic          m0_rty_o,

  input  logic          m1_cyc_i,
  input  logic          m1_stb_i,
  input  logic          m1_we_i,
  input  logic          m1_lock_i,
  input  logic [AW-1:0] m1_addr_i,
  input  logic [DW-1:0] m1_dat_i,
  input  logic [SW-1:0] m1_sel_i,
  output logic [DW-1:0] m1_dat_o,
  output logic          m1_ack_o,
  output logic          m1_err_o,
  output logic          m1_rty_o,

  output logic          s_cyc_o,
  output logic          s_stb_o,
  output logic          s_we_o,
  output logic          s_lock_o,
  output logic [AW-1:0] s_addr_o,
  output logic [DW-1:0] s_dat_o,
  output logic [SW-1:0] s_sel_o,
  input  logic [DW-1:0] s_dat_i,
  input  logic          s_ack_i,
  input  logic          s_err_i,
  input  logic          s_rty_i,

  output logic [1:0]    gnt_o
);

  // One-hot state encoding: bit gi set means master gi owns the bus, so the
  // state register doubles as the grant vector.
  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_GNT0 = 2'b01;
  localparam logic [1:0] ST_GNT1 = 2'b10;

  logic [1:0] state_reg, state_next;
  // Master granted most recently (0 = m0, 1 = m1). Resets to m1 so that m0
  // wins the first tie.
  logic       last_gnt_reg, last_gnt_next;

  // Master-side signals gathered into arrays indexed by master number.
  logic [1:0]    cyc, stb, we, lock;
  logic [AW-1:0] addr [2];
  logic [DW-1:0] wdat [2];
  logic [SW-1:0] sel  [2];

  assign cyc     = {m1_cyc_i,  m0_cyc_i};
  assign stb     = {m1_stb_i,  m0_stb_i};
  assign we      = {m1_we_i,   m0_we_i};
  assign lock    = {m1_lock_i, m0_lock_i};
  assign addr[0] = m0_addr_i;
  assign addr[1] = m1_addr_i;
  assign wdat[0] = m0_dat_i;
  assign wdat[1] = m1_dat_i;
  assign sel[0]  = m0_sel_i;
  assign sel[1]  = m1_sel_i;

  // Forced error from the stall timeout (constant low when not built in).
  logic timeout_hit;

  // ---------------------------------------------------------------------------
  // Grant FSM
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next    = state_reg;
    last_gnt_next = last_gnt_reg;
    case (state_reg)
      ST_IDLE: begin
        // Only live requests are considered, so a master that drops cyc
        // before being granted is simply forgotten.
        if (cyc == 2'b11) begin
          state_next    = last_gnt_reg ? ST_GNT0 : ST_GNT1;
          last_gnt_next = ~last_gnt_reg;
        end else if (cyc[0]) begin
          state_next    = ST_GNT0;
          last_gnt_next = 1'b0;
        end else if (cyc[1]) begin
          state_next    = ST_GNT1;
          last_gnt_next = 1'b1;
        end
      end
      // Release always goes through IDLE, giving one dead cycle between
      // grants even with the other master waiting.
      ST_GNT0: begin
        if (!cyc[0] && !lock[0]) begin
          state_next = ST_IDLE;
        end
      end
      ST_GNT1: begin
        if (!cyc[1] && !lock[1]) begin
          state_next = ST_IDLE;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg    <= ST_IDLE;
      last_gnt_reg <= 1'b1;
    end else begin
      state_reg    <= state_next;
      last_gnt_reg <= last_gnt_next;
    end
  end

  assign gnt_o = state_reg;

  // ---------------------------------------------------------------------------
  // Request mux towards the slave (combinational on registered state)
  // ---------------------------------------------------------------------------
  logic owner;
  assign owner = state_reg[1];

  always_comb begin
    s_cyc_o  = 1'b0;
    s_stb_o  = 1'b0;
    s_we_o   = 1'b0;
    s_lock_o = 1'b0;
    s_addr_o = '0;
    s_dat_o  = '0;
    s_sel_o  = '0;
    if (state_reg != ST_IDLE) begin
      s_cyc_o  = cyc[owner];
      s_stb_o  = stb[owner];
      s_we_o   = we[owner];
      s_lock_o = lock[owner];
      s_addr_o = addr[owner];
      s_dat_o  = wdat[owner];
      s_sel_o  = sel[owner];
    end
  end

  // ---------------------------------------------------------------------------
  // Response routing: only the granted master sees ack/err/rty
  // ---------------------------------------------------------------------------
  logic [1:0] m_ack, m_err, m_rty;

  for (genvar gi = 0; gi < 2; gi++) begin : g_resp
    assign m_ack[gi] = state_reg[gi] & s_ack_i;
    // A timeout error supersedes whatever the slave drives on err.
    assign m_err[gi] = state_reg[gi] & (timeout_hit | s_err_i);
    assign m_rty[gi] = state_reg[gi] & s_rty_i;
  end

  assign m0_ack_o = m_ack[0];
  assign m0_err_o = m_err[0];
  assign m0_rty_o = m_rty[0];
  assign m1_ack_o = m_ack[1];
  assign m1_err_o = m_err[1];
  assign m1_rty_o = m_rty[1];

  assign m0_dat_o = s_dat_i;
  assign m1_dat_o = s_dat_i;

  // ---------------------------------------------------------------------------
  // Optional stall timeout
  // ---------------------------------------------------------------------------
`ifdef WB_ARB_TIMEOUT_EN
  localparam int CW = (TIMEOUT_CYCLES < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] stall_cnt_reg, stall_cnt_next;
  logic          slave_resp;

  assign slave_resp  = s_ack_i | s_err_i | s_rty_i;
  // The counter value equals the number of stalled strobe cycles already
  // seen, so the error lands in the cycle after TIMEOUT_CYCLES stalls.
  assign timeout_hit = s_stb_o && (stall_cnt_reg == CW'(TIMEOUT_CYCLES));

  always_comb begin
    stall_cnt_next = stall_cnt_reg;
    if (timeout_hit || slave_resp || (state_next != state_reg)) begin
      stall_cnt_next = '0;
    end else if (s_stb_o) begin
      stall_cnt_next = stall_cnt_reg + CW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stall_cnt_reg <= '0;
    end else begin
      stall_cnt_reg <= stall_cnt_next;
    end
  end
`else
  // No stall limit in this build: the comparison is constant false and only
  // keeps the (unused) limit parameter referenced.
  assign timeout_hit = (TIMEOUT_CYCLES < 0);
`endif

endmodule

// File: doc/wb_arbiter_2m.md
Name: wb_arbiter_2m

Overview:
- Two-master, one-slave Wishbone arbiter in front of the frequency counter's shared slave bus (measurement/config registers).
- Master 0 is control_unit; master 1 is the UART command bridge.
- Grants the bus per Wishbone cycle with round-robin fairness and LOCK support.
- Muxes the granted master onto the slave and routes slave responses back to it only.

Parameters:
- AW, 32, address width
- DW, 32, data width
- SW, 8, select width
- TIMEOUT_CYCLES, 255, stall limit before forced error (used only with the optional feature)

Ports:
- clk_i  input  1  system clock
- rst_i  input  1  reset, synchronous, active-high
- m0_cyc_i / m1_cyc_i  input  1  master cycle request
- m0_stb_i / m1_stb_i  input  1  master strobe
- m0_we_i / m1_we_i  input  1  master write enable
- m0_lock_i / m1_lock_i  input  1  master bus lock
- m0_addr_i / m1_addr_i  input  AW  master address
- m0_dat_i / m1_dat_i  input  DW  master write data
- m0_sel_i / m1_sel_i  input  SW  master byte select
- m0_dat_o / m1_dat_o  output  DW  read data to master
- m0_ack_o / m1_ack_o  output  1  ack to master
- m0_err_o / m1_err_o  output  1  error to master
- m0_rty_o / m1_rty_o  output  1  retry to master
- s_cyc_o, s_stb_o, s_we_o, s_lock_o  output  1 each  slave control
- s_addr_o  output  AW  slave address
- s_dat_o  output  DW  slave write data
- s_sel_o  output  SW  slave select
- s_dat_i  input  DW  slave read data
- s_ack_i, s_err_i, s_rty_i  input  1 each  slave responses
- gnt_o  output  2  one-hot grant status (bit0 = m0, bit1 = m1)

Behaviour:
- States IDLE, GNT0, GNT1. The state register and last_gnt register are the only sequential state (plus the timeout counter when enabled).
- Reset: state = IDLE, last_gnt = m1, so m0 wins the first tie. gnt_o = 0. All s_* outputs = 0. All m*_ack/err/rty = 0.
- IDLE, only m0_cyc_i high -> GNT0 next cycle; only m1_cyc_i high -> GNT1.
- IDLE, both high -> grant the master not equal to last_gnt. last_gnt updates on entry to a GNT state.
- Grant latency: request at edge N, grant registered at N+1. The slave sees s_cyc_o/s_stb_o from cycle N+1 onward.
- GNTx holds while mx_cyc_i = 1 or mx_lock_i = 1.
- GNTx -> IDLE when mx_cyc_i = 0 and mx_lock_i = 0. There is always exactly one IDLE cycle between grants, even with the other master waiting.
- Slave outputs are a combinational mux on the registered state: GNTx drives s_* = mx_*. In IDLE, all s_* = 0.
- Response routing: s_ack_i/err_i/rty_i go to the granted master only; the non-granted master sees 0. s_dat_i is broadcast to both m*_dat_o.
- Simultaneous slave ack and granted-master cyc drop in the same cycle: ack is delivered, then IDLE next edge.
- A master that drops cyc before it is granted is never granted.
- Reset mid-transfer: next edge returns to IDLE and all outputs to reset values. The pending transfer is abandoned with no ack.

Optional Feature:
- Macro: WB_ARB_TIMEOUT_EN.
- With the macro: a counter increments each cycle s_stb_o = 1 with no slave ack/err/rty.
  - On reaching TIMEOUT_CYCLES it drives mx_err_o = 1 to the granted master for one cycle, s_err_i is ignored in that cycle, and the counter clears.
  - The counter also clears on any slave response, on a state change, and on reset.
- Without the macro: no counter; the arbiter waits indefinitely; TIMEOUT_CYCLES is unused.

Test Plan:
- Single master: reset, m0 read addr 0x10, slave acks 2 cycles after stb with dat 0xDEADBEEF -> gnt_o = 01 one cycle after request; m0_ack_o = 1 with m0_dat_o = 0xDEADBEEF; m1_ack_o stays 0.
- Tie: m0 and m1 raise cyc in the same cycle after reset -> m0 granted first. After m0 drops cyc: one IDLE cycle, then gnt_o = 10. A second simultaneous request -> m0 (alternation).
- Lock: m1 sets lock with two cycles, cyc low between them, while m0 requests continuously -> gnt_o stays 10 until m1 lock and cyc are both 0.
- Error/retry: slave asserts s_err_i then s_rty_i during an m0 write -> only m0_err_o/m0_rty_o pulse; s_we_o = 1, s_sel_o = m0_sel_i.
- Reset mid-cycle: assert rst_i while GNT1 and s_stb_o high -> next edge s_cyc_o = 0, gnt_o = 00, no ack to m1.
- Timeout (WB_ARB_TIMEOUT_EN, TIMEOUT_CYCLES = 8): slave never responds -> m0_err_o pulses exactly once, 8 cycles after stb; without the macro, no err after 100 cycles.
